// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and write-request type for the register-file write-back arbiter.
package regfile_write_arbiter_pkg;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_dec.sv
// Write-select decoder: one-hot of addr when en is high, all zero otherwise.
module regfile_write_arbiter_dec #(
  parameter int AW = 5
) (
  input  logic                en,
  input  logic [AW-1:0]       addr,
  output logic [(2**AW)-1:0]  onehot
);

  // One-hot decode gated by the enable
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write-back arbiter feeding a registered register-file
// write port, with a stall input that freezes the output stage and the pointer.
module regfile_write_arbiter #(
  parameter int NREQ = regfile_write_arbiter_pkg::NREQ,
  parameter int AW   = regfile_write_arbiter_pkg::AW,
  parameter int DW   = regfile_write_arbiter_pkg::DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     rf_hold,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_wa,
  output logic [DW-1:0]            rf_wd,
  output logic [31:0]              pending
);

  import regfile_write_arbiter_pkg::*;

  logic             rr_ptr_r;
  logic [NREQ-1:0]  grant_s;
  logic             xfer_s;
  wr_req_t          sel_req_s;

  // Round-robin grant: preferred requester first, otherwise the other one
  always_comb begin
    grant_s = '0;
    if (reset || rf_hold) begin
      grant_s = '0;
    end else begin
      case (rr_ptr_r)
        1'b0: begin
          if (req_valid[0])      grant_s = 2'b01;
          else if (req_valid[1]) grant_s = 2'b10;
          else                   grant_s = 2'b00;
        end
        1'b1: begin
          if (req_valid[1])      grant_s = 2'b10;
          else if (req_valid[0]) grant_s = 2'b01;
          else                   grant_s = 2'b00;
        end
        default: grant_s = 2'b00;
      endcase
    end
  end

  assign req_ready = grant_s;
  assign xfer_s    = |grant_s;

  // Mux the granted request into a single write-request record
  always_comb begin
    sel_req_s = '0;
    if (grant_s[1]) begin
      sel_req_s = {req_valid[1], req_addr[1], req_data[1]};
    end else begin
      sel_req_s = {req_valid[0], req_addr[0], req_data[0]};
    end
  end

  // Output register stage and round-robin pointer; register 0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_wa    <= {AW{1'b0}};
      rf_wd    <= {DW{1'b0}};
      rr_ptr_r <= 1'b0;
    end else if (rf_hold) begin
      rf_we    <= rf_we;
      rf_wa    <= rf_wa;
      rf_wd    <= rf_wd;
      rr_ptr_r <= rr_ptr_r;
    end else if (xfer_s) begin
      rf_we    <= (sel_req_s.addr != {AW{1'b0}});
      rf_wa    <= sel_req_s.addr;
      rf_wd    <= sel_req_s.data;
      rr_ptr_r <= ~grant_s[1];
    end else begin
      rf_we    <= 1'b0;
      rf_wa    <= rf_wa;
      rf_wd    <= rf_wd;
      rr_ptr_r <= rr_ptr_r;
    end
  end

  regfile_write_arbiter_dec #(.AW(AW)) u_dec (
    .en     (rf_we),
    .addr   (rf_wa),
    .onehot (pending)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the driver pushes expected register writes on each grant;
// a monitor pops and compares whenever a write commits (rf_we=1, rf_hold=0).
module tb_regfile_write_arbiter;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0][4:0]  req_addr;
  logic [1:0][31:0] req_data;
  logic [1:0]       req_ready;
  logic             rf_hold;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [31:0]      rf_wd;
  logic [31:0]      pending;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   commits  = 0;
  logic mon_en   = 1'b0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_hold   (rf_hold),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Wait for mid-cycle, check the grant and record the write it should produce
  task automatic sample(input string name, input logic [1:0] exp_rdy);
    exp_t e;
    @(negedge clk);
    chk(name, {30'd0, req_ready}, {30'd0, exp_rdy});
    if (exp_rdy[0] && req_addr[0] != 5'd0) begin
      e.a = req_addr[0]; e.d = req_data[0]; q.push_back(e);
    end
    if (exp_rdy[1] && req_addr[1] != 5'd0) begin
      e.a = req_addr[1]; e.d = req_data[1]; q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rf_we === 1'b1 && rf_hold === 1'b0) begin
        if (q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL sb_unexpected_write actual_wa=%0d required=no_write", rf_wa);
        end else begin
          e = q.pop_front();
          commits++;
          chk("sb_wa", {27'd0, rf_wa}, {27'd0, e.a});
          chk("sb_wd", rf_wd, e.d);
          chk("sb_pending", pending, 32'd1 << e.a);
        end
      end else if (rf_we !== 1'b1) begin
        chk("idle_pending", pending, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rf_hold = 1'b0; req_valid = 2'b11;
    req_addr[0] = 5'd3; req_addr[1] = 5'd4;
    req_data[0] = 32'h1111_1111; req_data[1] = 32'h2222_2222;
    #1;
    tick(); tick();
    sample("rst_ready", 2'b00);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_wa", {27'd0, rf_wa}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_pending", pending, 32'd0);
    mon_en = 1'b1;
    tick();

    // Single write from requester 0
    reset = 1'b0;
    req_valid = 2'b01; req_addr[0] = 5'd8; req_data[0] = 32'hDEAD_BEEF;
    sample("t032_ready", 2'b01); tick();
    req_valid = 2'b00;
    sample("t032_idle_ready", 2'b00);
    chk("t032_we", {31'd0, rf_we}, 32'd1);
    chk("t032_wa", {27'd0, rf_wa}, 32'd8);
    chk("t032_pending", pending, 32'h0000_0100);
    tick();

    // Pointer is now 1; a lone requester-1 write moves it back to 0
    req_valid = 2'b10; req_addr[1] = 5'd5; req_data[1] = 32'h0000_0055;
    sample("ptr_ready", 2'b10); tick();

    // Sustained contention alternates 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11; req_addr[0] = 5'd3; req_addr[1] = 5'd4;
      req_data[0] = 32'h3000_0000 | 32'(k); req_data[1] = 32'h4000_0000 | 32'(k);
      sample("t033_ready", (k % 2 == 0) ? 2'b01 : 2'b10); tick();
    end

    // Write to register 0 is accepted but suppressed
    req_valid = 2'b01; req_addr[0] = 5'd0; req_data[0] = 32'h0000_1234;
    sample("t034_ready", 2'b01); tick();
    req_valid = 2'b11; req_addr[0] = 5'd3; req_data[0] = 32'h0000_0033;
    req_addr[1] = 5'd4; req_data[1] = 32'h0000_0044;
    sample("t034_ptr_adv", 2'b10);
    chk("t034_we", {31'd0, rf_we}, 32'd0);
    chk("t034_pending", pending, 32'd0);
    tick();

    // Write to 31, then three hold cycles with requester 1 waiting
    req_valid = 2'b01; req_addr[0] = 5'd31; req_data[0] = 32'hCAFE_F00D;
    sample("t035_ready", 2'b01); tick();
    for (int h = 0; h < 3; h++) begin
      rf_hold = 1'b1; req_valid = 2'b10; req_addr[1] = 5'd7; req_data[1] = 32'h0000_0077;
      sample("t035_hold_ready", 2'b00);
      chk("t035_hold_we", {31'd0, rf_we}, 32'd1);
      chk("t035_hold_wa", {27'd0, rf_wa}, 32'd31);
      tick();
    end
    rf_hold = 1'b0;
    sample("t035_resume_ready", 2'b10);
    chk("t035_last_we", {31'd0, rf_we}, 32'd1);
    chk("t035_last_wa", {27'd0, rf_wa}, 32'd31);
    tick();
    req_valid = 2'b00;
    sample("idle_ready", 2'b00); tick();

    // Reset while a write is held discards it
    req_valid = 2'b01; req_addr[0] = 5'd9; req_data[0] = 32'h0000_0099;
    sample("t036_ready", 2'b01); tick();
    rf_hold = 1'b1; req_valid = 2'b00;
    sample("t036_hold_ready", 2'b00); tick();
    reset = 1'b1; req_valid = 2'b11;
    sample("t036_rst_ready", 2'b00);
    chk("t036_held_we", {31'd0, rf_we}, 32'd1);
    tick();
    q.delete();
    reset = 1'b0; rf_hold = 1'b0;
    req_addr[0] = 5'd3; req_data[0] = 32'h0000_0333;
    req_addr[1] = 5'd4; req_data[1] = 32'h0000_0444;
    sample("t036_first_grant", 2'b01);
    chk("t036_we", {31'd0, rf_we}, 32'd0);
    chk("t036_wa", {27'd0, rf_wa}, 32'd0);
    chk("t036_wd", rf_wd, 32'd0);
    chk("t036_pending", pending, 32'd0);
    tick();
    req_valid = 2'b00;
    sample("tail_ready", 2'b00); tick();
    sample("tail_ready", 2'b00); tick();

    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("commit_count", 32'(commits), 32'd10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: NREQ, 2, number of write-back requesters; this revision supports exactly 2.
REQ-002 Parameter: AW, 5, register address width; drives the 5-to-32 write-select decoder.
REQ-003 Parameter: DW, 32, register data width.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: req_valid  in  NREQ  requester i holds a write.
REQ-007 Port: req_addr  in  NREQ x AW  destination register per requester.
REQ-008 Port: req_data  in  NREQ x DW  write data per requester.
REQ-009 Port: req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are high at an edge.
REQ-010 Port: rf_hold  in  1  register-file port unavailable; freezes output stage.
REQ-011 Port: rf_we  out  1  register-file write enable, registered.
REQ-012 Port: rf_wa  out  AW  write address to the write-select decoder, registered.
REQ-013 Port: rf_wd  out  DW  write data, registered.
REQ-014 Port: pending  out  32  one-hot of rf_wa when rf_we=1, else zero; hazard/forwarding view.

Function
REQ-015 req_ready is combinational: all zero when rf_hold=1 or reset=1; otherwise at most one bit high, chosen among valid requesters by round-robin.
REQ-016 Round-robin: pointer rr_ptr names the preferred requester; if req_valid[rr_ptr], grant it, else grant the other if valid.
REQ-017 On every accepted transfer, rr_ptr moves to the requester after the granted one (mod NREQ); with no transfer, rr_ptr holds.
REQ-018 Latency: transfer at edge N yields rf_we/rf_wa/rf_wd driven from edge N until edge N+1 (one cycle), unless held.
REQ-019 Transfer with req_addr=0: accepted (ready pulses, rr_ptr advances) but rf_we=0 on the next cycle; register 0 is never written.
REQ-020 Cycle with no transfer and rf_hold=0: rf_we=0 next cycle; rf_wa/rf_wd hold previous values.
REQ-021 rf_hold=1: rf_we, rf_wa, rf_wd, rr_ptr all hold; no grant; requesters keep valid and stable data (requester obligation).
REQ-022 rf_hold falling: arbitration resumes that same cycle; the held write is considered committed on the first edge with rf_hold=0.
REQ-023 Both requesters valid with same nonzero address: loser waits; writes commit in grant order, never merged or dropped.
REQ-024 Sustained contention: grants strictly alternate, each requester served within 2 cycles of rf_hold=0 availability.
REQ-025 pending equals decode of rf_wa gated by rf_we, combinational from registered state (no extra latency).
REQ-026 Requester may drop req_valid without a transfer; no state changes.

Reset
REQ-027 reset=1 at an edge: rf_we=0, rf_wa=0, rf_wd=0, rr_ptr=0, pending=0; overrides rf_hold and any request in that cycle.
REQ-028 Reset mid-hold discards the held write; first grant after reset goes to requester 0 if valid.

Structure
REQ-029 Shared package holds AW, DW, NREQ constants and the write-request struct (valid, addr, data).
REQ-030 pending generation instantiates the existing 5-to-32 decoder as the single sub-module (output gated by rf_we).
REQ-031 State: output register stage and rr_ptr only; no FIFO; target 150-250 lines of RTL.

Verification
REQ-032 Reset released, req0 valid addr=8 data=0xDEADBEEF -> ready0=1 same cycle; next cycle rf_we=1, rf_wa=8, rf_wd=0xDEADBEEF, pending=0x00000100.
REQ-033 Both valid 4 cycles (req0 addr=3, req1 addr=4), rr_ptr=0 -> grants 0,1,0,1; rf_wa sequence 3,4,3,4.
REQ-034 Write to addr=0 data=0x1234 -> ready pulses, next cycle rf_we=0, pending=0, rr_ptr advanced.
REQ-035 Write addr=31 accepted, then rf_hold=1 for 3 cycles with req1 valid -> rf_we=1, rf_wa=31 held 4 cycles, ready=00 during hold, req1 granted first cycle hold drops.
REQ-036 reset asserted during rf_hold with rf_we=1 -> next cycle rf_we=0, rf_wa=0, pending=0, rr_ptr=0.
